mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter that shares the unified 16-bit big-endian instruction/data memory between the fetch stage and the memory (load/store) stage. Per cycle it grants at most one requester, drives the memory's address/enable/write/data lines, and returns read data and alignment error to the granted requester with registered one-cycle latency. Data accesses have priority. A bounded streak counter guarantees fetch forward progress, and a fetch flush input discards stale fetch responses.

## Interface
Parameters:
- `MAX_DATA_STREAK`, default 4: the maximum number of consecutive data grants allowed while a fetch request is waiting. Legal range is 1..15.

Ports:
- `clk` in 1: the single clock. All state updates on posedge.
- `rst` in 1: reset, synchronous, active-low. Asserted when 0.
- `if_req_valid` in 1: fetch read request.
- `if_req_addr` in 16: fetch byte address.
- `if_req_ready` out 1: fetch request granted this cycle.
- `if_flush` in 1: redirect. Kills fetch traffic (see Operation).
- `if_rsp_valid` out 1: fetch response valid.
- `if_rsp_data` out 16: fetch read data.
- `if_rsp_err` out 1: misaligned fetch.
- `dm_req_valid` in 1: data request.
- `dm_req_addr` in 16: data byte address.
- `dm_req_wr` in 1: 1 = store, 0 = load.
- `dm_req_wdata` in 16: store data.
- `dm_req_ready` out 1: data request granted this cycle.
- `dm_rsp_valid` out 1: data response valid. Issued for loads and stores.
- `dm_rsp_data` out 16: load data. 0 for stores.
- `dm_rsp_err` out 1: misaligned data access.
- `mem_addr` out 16: memory address.
- `mem_enable` out 1: memory enable.
- `mem_wr` out 1: memory write.
- `mem_data_in` out 16: memory write data.
- `mem_data_out` in 16: memory read data. Combinational, same cycle.
- `mem_err` in 1: memory misalignment flag. Combinational, same cycle.

## Operation
- Grant decision is combinational in cycle N. The winner's request drives the `mem_*` lines in N. `*_req_ready` is high only for the winner.
- Priority:
  - Data wins by default.
  - Fetch wins if `if_req_valid` and `streak == MAX_DATA_STREAK`.
  - Fetch is never granted while `if_flush` = 1.
- `streak` counter, 4 bits:
  - Increments on a data grant while `if_req_valid` = 1.
  - Clears on a fetch grant, or in any cycle with `if_req_valid` = 0.
  - Saturates at `MAX_DATA_STREAK`.
- No grant: `mem_enable` = 0, `mem_wr` = 0, `mem_addr` = 0, `mem_data_in` = 0.
- Fetch grant: `mem_enable` = 1, `mem_wr` = 0, `mem_addr` = `if_req_addr`, `mem_data_in` = 0.
- Data grant: `mem_enable` = 1, `mem_wr` = `dm_req_wr`, `mem_addr` = `dm_req_addr`, `mem_data_in` = `dm_req_wdata`.
- Response register `owner`, with encoding `OWN_NONE` / `OWN_IF` / `OWN_DM`. At posedge ending N it captures:
  - the winner;
  - `mem_data_out`, forced to 0 for stores;
  - `mem_err`.
- Outputs in N+1:
  - `if_rsp_valid` = (`owner` == `OWN_IF`) & ~`if_flush`.
  - `dm_rsp_valid` = (`owner` == `OWN_DM`).
  - Data and err are the registered values. Data and err read 0 when the matching valid is 0.
- Misaligned access (`addr[0]` = 1): the memory suppresses the write. The arbiter still grants, returns data 0, and sets `rsp_err` = 1. It does not retry.
- Reset (`rst` = 0):
  - All `*_ready` = 0 and all `mem_*` = 0.
  - `owner` = `OWN_NONE`, `streak` = 0.
  - All `*_rsp_*` = 0 from the cycle after reset is sampled.
  - Reset asserted in the cycle a response is pending drops that response. No grant is issued while `rst` = 0.

## Timing
- Request-to-response latency is exactly 1 cycle. Throughput is one access per cycle, with no bubbles between back-to-back grants.
- A requester holds valid and payload stable until `ready` is seen. The arbiter does not buffer ungranted requests.
- `if_flush` in N:
  - blocks a fetch grant in N;
  - suppresses the fetch response that would appear in N;
  - does not affect data traffic or `streak`.
- Simultaneous `if_req_valid` and `dm_req_valid` with `streak` < MAX: data is granted. The fetch waits at most `MAX_DATA_STREAK` cycles plus any flush cycles.
- A store is visible to a load or fetch granted in the very next cycle, because the memory writes at the posedge.

## Structure
- Shared package `mem_arb_pkg`:
  - `owner_e` enum (`OWN_NONE`, `OWN_IF`, `OWN_DM`);
  - `ADDR_W` = 16, `DATA_W` = 16;
  - `STREAK_W` = 4.
- One sub-module, `mem_arb_pick`: combinational priority and starvation decision. It takes both valids, `if_flush`, `rst` and `streak`, and produces the grant vector.
- The top level holds the `streak` counter, the response register and the `mem_*` mux.

## Test plan
- Lone fetch at 0x0010, memory holding 0xBEEF at 0x0010/0x0011 -> `if_req_ready` = 1 in N; in N+1 `if_rsp_valid` = 1, `if_rsp_data` = 0xBEEF, `if_rsp_err` = 0.
- Store 0x1234 to 0x0020 in N, load 0x0020 in N+1 -> `dm_rsp_valid` in N+1 with data 0; in N+2 `dm_rsp_data` = 0x1234.
- Fetch and data requests both valid continuously, `MAX_DATA_STREAK` = 4 -> grant pattern D,D,D,D,F repeating. The fetch is never starved more than 4 cycles.
- Data load at 0x0031 -> grant; next cycle `dm_rsp_err` = 1, data 0. A store to 0x0031 leaves 0x0030/0x0031 unchanged.
- Fetch granted in N, `if_flush` = 1 in N+1 -> `if_rsp_valid` = 0 in N+1, and no fetch grant in N+1.
- `rst` = 0 in the cycle after a grant -> next cycle all `rsp_valid` = 0, `mem_enable` = 0, `streak` = 0. After release, the first grant behaves as from idle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the fetch/data memory arbiter.
// Both the top level and the grant picker import this package.
package mem_arb_pkg;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 16;
    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    typedef struct packed {
        logic if_gnt;
        logic dm_gnt;
    } grant_t;

    // A byte address with bit 0 set cannot form a 16-bit word access.
    function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
        return addr[0];
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant decision: data first, unless a waiting fetch has hit the
// streak limit. Flush and reset both suppress fetch grants.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                rst,
    input  logic                if_req_valid,
    input  logic                dm_req_valid,
    input  logic                if_flush,
    input  logic [STREAK_W-1:0] streak,
    output grant_t              grant
);

    logic fetch_ok_s;

    // Priority resolution; the result is one-hot or all zero.
    always_comb begin
        grant      = '0;
        fetch_ok_s = if_req_valid & ~if_flush;
        if (!rst) begin
            grant = '0;
        end else if (fetch_ok_s && (streak == STREAK_W'(MAX_DATA_STREAK))) begin
            grant.if_gnt = 1'b1;
        end else if (dm_req_valid) begin
            grant.dm_gnt = 1'b1;
        end else if (fetch_ok_s) begin
            grant.if_gnt = 1'b1;
        end else begin
            grant = '0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch and load/store. Grants one access per
// cycle, drives the memory port, and returns data/err one cycle later.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    input  logic              if_flush,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    output logic              if_rsp_err,
    input  logic              dm_req_valid,
    input  logic [ADDR_W-1:0] dm_req_addr,
    input  logic              dm_req_wr,
    input  logic [DATA_W-1:0] dm_req_wdata,
    output logic              dm_req_ready,
    output logic              dm_rsp_valid,
    output logic [DATA_W-1:0] dm_rsp_data,
    output logic              dm_rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_err
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    grant_t              grant_s;
    logic [STREAK_W-1:0] streak_d, streak_q;
    owner_e              owner_d, owner_q;
    logic [DATA_W-1:0]   rsp_data_d, rsp_data_q;
    logic                rsp_err_d, rsp_err_q;

    mem_arb_pick #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_pick (
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .dm_req_valid (dm_req_valid),
        .if_flush     (if_flush),
        .streak       (streak_q),
        .grant        (grant_s)
    );

    assign if_req_ready = grant_s.if_gnt;
    assign dm_req_ready = grant_s.dm_gnt;

    // Memory port mux; idle lines are held at zero.
    always_comb begin
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        case ({grant_s.if_gnt, grant_s.dm_gnt})
            2'b10: begin
                mem_enable = 1'b1;
                mem_addr   = if_req_addr;
            end
            2'b01: begin
                mem_enable  = 1'b1;
                mem_wr      = dm_req_wr;
                mem_addr    = dm_req_addr;
                mem_data_in = dm_req_wdata;
            end
            default: begin
                mem_enable  = 1'b0;
                mem_wr      = 1'b0;
                mem_addr    = '0;
                mem_data_in = '0;
            end
        endcase
    end

    // Streak counts data grants taken while a fetch is waiting; flush leaves it alone.
    always_comb begin
        streak_d = streak_q;
        if (!rst) begin
            streak_d = '0;
        end else if (!if_req_valid || grant_s.if_gnt) begin
            streak_d = '0;
        end else if (grant_s.dm_gnt) begin
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
        end else begin
            streak_d = streak_q;
        end
    end

    // Response capture; stores and misaligned accesses return zero data.
    always_comb begin
        owner_d    = OWN_NONE;
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
        if (!rst) begin
            owner_d = OWN_NONE;
        end else if (mem_enable) begin
            owner_d    = grant_s.if_gnt ? OWN_IF : OWN_DM;
            rsp_err_d  = mem_err;
            rsp_data_d = (mem_wr || mem_err || is_misaligned(mem_addr)) ? '0 : mem_data_out;
        end else begin
            owner_d = OWN_NONE;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            streak_q   <= '0;
            owner_q    <= OWN_NONE;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            streak_q   <= streak_d;
            owner_q    <= owner_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // A flush in the response cycle kills the fetch response that is landing now.
    assign if_rsp_valid = (owner_q == OWN_IF) & ~if_flush;
    assign if_rsp_data  = if_rsp_valid ? rsp_data_q : '0;
    assign if_rsp_err   = if_rsp_valid & rsp_err_q;
    assign dm_rsp_valid = (owner_q == OWN_DM);
    assign dm_rsp_data  = dm_rsp_valid ? rsp_data_q : '0;
    assign dm_rsp_err   = dm_rsp_valid & rsp_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a rule-level model
// plus a behavioural big-endian word memory.
module tb_mem_arbiter;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_flush;
    logic [15:0] if_req_addr;
    logic        if_rsp_valid, if_rsp_err;
    logic [15:0] if_rsp_data;
    logic        dm_req_valid, dm_req_wr, dm_req_ready;
    logic [15:0] dm_req_addr, dm_req_wdata;
    logic        dm_rsp_valid, dm_rsp_err;
    logic [15:0] dm_rsp_data;
    logic [15:0] mem_addr, mem_data_in, mem_data_out;
    logic        mem_enable, mem_wr, mem_err;

    logic [15:0] mem_w [0:127];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int          m_streak = 0;
    int          m_pend   = 0;     // 0 none, 1 fetch, 2 data
    logic [15:0] m_data   = 16'h0000;
    logic        m_err    = 1'b0;
    int          wait_cnt = 0;
    int          max_wait = 0;

    always #5 clk = ~clk;

    assign mem_data_out = mem_w[mem_addr[7:1]];
    assign mem_err      = mem_enable & mem_addr[0];

    mem_arbiter #(.MAX_DATA_STREAK(MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_addr  (if_req_addr),
        .if_req_ready (if_req_ready),
        .if_flush     (if_flush),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .if_rsp_err   (if_rsp_err),
        .dm_req_valid (dm_req_valid),
        .dm_req_addr  (dm_req_addr),
        .dm_req_wr    (dm_req_wr),
        .dm_req_wdata (dm_req_wdata),
        .dm_req_ready (dm_req_ready),
        .dm_rsp_valid (dm_rsp_valid),
        .dm_rsp_data  (dm_rsp_data),
        .dm_rsp_err   (dm_rsp_err),
        .mem_addr     (mem_addr),
        .mem_enable   (mem_enable),
        .mem_wr       (mem_wr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_err      (mem_err)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [15:0] read_word(input logic [15:0] a);
        return mem_w[a[7:1]];
    endfunction

    // One clock cycle: drive, predict, compare, then let the memory commit its write.
    task automatic step(input logic r, input logic ifv, input logic [15:0] ifa, input logic fl,
                        input logic dmv, input logic [15:0] dma, input logic wr,
                        input logic [15:0] wd, output int gnt);
        int          g;
        logic        w_en;
        logic [15:0] w_addr, w_data;
        rst = r; if_req_valid = ifv; if_req_addr = ifa; if_flush = fl;
        dm_req_valid = dmv; dm_req_addr = dma; dm_req_wr = wr; dm_req_wdata = wd;
        #3;
        if (!r)                                g = 0;
        else if (ifv && !fl && m_streak == MAX) g = 1;
        else if (dmv)                          g = 2;
        else if (ifv && !fl)                   g = 1;
        else                                   g = 0;

        check_eq("if_req_ready", 16'(if_req_ready), 16'(g == 1));
        check_eq("dm_req_ready", 16'(dm_req_ready), 16'(g == 2));
        check_eq("mem_enable",   16'(mem_enable),   16'(g != 0));
        check_eq("mem_wr",       16'(mem_wr),       16'(g == 2 && wr));
        check_eq("mem_addr",     mem_addr,    (g == 1) ? ifa : (g == 2) ? dma : 16'h0000);
        check_eq("mem_data_in",  mem_data_in, (g == 2) ? wd : 16'h0000);
        if (r) begin
            check_eq("if_rsp_valid", 16'(if_rsp_valid), 16'(m_pend == 1 && !fl));
            check_eq("if_rsp_data",  if_rsp_data, (m_pend == 1 && !fl) ? m_data : 16'h0000);
            check_eq("if_rsp_err",   16'(if_rsp_err), 16'(m_pend == 1 && !fl && m_err));
            check_eq("dm_rsp_valid", 16'(dm_rsp_valid), 16'(m_pend == 2));
            check_eq("dm_rsp_data",  dm_rsp_data, (m_pend == 2) ? m_data : 16'h0000);
            check_eq("dm_rsp_err",   16'(dm_rsp_err), 16'(m_pend == 2 && m_err));
        end

        // Next response
        m_pend = g;
        if (g == 1) begin
            m_err  = ifa[0];
            m_data = ifa[0] ? 16'h0000 : read_word(ifa);
        end else if (g == 2) begin
            m_err  = dma[0];
            m_data = (wr || dma[0]) ? 16'h0000 : read_word(dma);
        end else begin
            m_err  = 1'b0;
            m_data = 16'h0000;
        end

        // Consecutive data grants seen by a waiting fetch
        if (!r || !ifv || g == 1) m_streak = 0;
        else if (g == 2)          m_streak = (m_streak < MAX) ? m_streak + 1 : MAX;

        if (!r || !ifv || g == 1) wait_cnt = 0;
        else if (!fl) begin
            wait_cnt++;
            if (wait_cnt > max_wait) max_wait = wait_cnt;
        end

        w_en = mem_enable & mem_wr & ~mem_addr[0];
        w_addr = mem_addr; w_data = mem_data_in;
        @(posedge clk);
        #1;
        if (w_en) mem_w[w_addr[7:1]] = w_data;
        gnt = g;
    endtask

    initial begin
        int g;
        logic        if_act, dm_act, dm_wr_r;
        logic [15:0] if_a, dm_a, dm_d;

        for (int i = 0; i < 128; i++) mem_w[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
        mem_w[8]  = 16'hBEEF;
        mem_w[24] = 16'hC0DE;

        rst = 1'b0; if_req_valid = 1'b0; if_req_addr = 16'h0000; if_flush = 1'b0;
        dm_req_valid = 1'b0; dm_req_addr = 16'h0000; dm_req_wr = 1'b0; dm_req_wdata = 16'h0000;
        @(posedge clk); #1;
        step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b1, 16'h0020, 1'b1, 16'h1111, g);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, g);

        // Lone fetch
        step(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, g);
        check_eq("lone_fetch_grant", 16'(g), 16'd1);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, g);

        // Store then load the same word
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0020, 1'b1, 16'h1234, g);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0020, 1'b0, 16'h0000, g);
        check_eq("store_fwd_model", m_data, 16'h1234);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, g);

        // Contention: D,D,D,D,F repeating
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0050, 1'b0, 16'h0000, g);
            check_eq("streak_pattern", 16'(g), (i % 5 == 4) ? 16'd1 : 16'd2);
        end
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, g);

        // Misaligned load and store
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0031, 1'b0, 16'h0000, g);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0031, 1'b1, 16'hFFFF, g);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0030, 1'b0, 16'h0000, g);
        check_eq("misaligned_store_kept", m_data, 16'hC0DE);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, g);

        // Flush right after a fetch grant
        step(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, g);
        step(1'b1, 1'b1, 16'h0012, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, g);
        check_eq("flush_blocks_grant", 16'(g), 16'd0);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, g);

        // Reset after a grant with the streak partly built
        step(1'b1, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0050, 1'b0, 16'h0000, g);
        step(1'b1, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0050, 1'b0, 16'h0000, g);
        step(1'b0, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0050, 1'b0, 16'h0000, g);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0052, 1'b0, 16'h0000, g);
            check_eq("post_reset_pattern", 16'(g), (i == 4) ? 16'd1 : 16'd2);
        end

        // Randomized traffic with requests held until granted
        if_act = 1'b0; dm_act = 1'b0; dm_wr_r = 1'b0;
        if_a = 16'h0000; dm_a = 16'h0000; dm_d = 16'h0000;
        for (int i = 0; i < 3000; i++) begin
            logic r, fl;
            r  = ($urandom_range(99) != 0);
            fl = ($urandom_range(9) == 0);
            if (!if_act && $urandom_range(9) < 7) begin
                if_act = 1'b1; if_a = 16'($urandom_range(255));
            end
            if (fl && $urandom_range(1) == 1) if_a = 16'($urandom_range(255));
            if (!dm_act && $urandom_range(9) < 6) begin
                dm_act = 1'b1; dm_a = 16'($urandom_range(255));
                dm_wr_r = 1'($urandom_range(1)); dm_d = 16'($urandom);
            end
            step(r, if_act, if_a, fl, dm_act, dm_a, dm_wr_r, dm_d, g);
            if (g == 1) if_act = 1'b0;
            if (g == 2) dm_act = 1'b0;
        end

        check_eq("if_wait_bound", 16'(max_wait <= MAX), 16'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
